sdram_port_arbiter: RTL and testbench

- Round-robin arbiter that multiplexes the left and right sample-storage channels onto the single hardware-only SDRAM controller.
- Replaces LRCLK-phase steering of the controller's address/data/enable lines with a proper request/grant scheme.
- Guarantees one-cycle enable pulses, no lost requests, and per-channel read-data routing.
- Sits between the two channel sample-storage blocks (upstream) and the SDRAM controller (downstream), in the clk50 domain.

---
 rtl/sdram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Round-robin request/grant arbiter that shares one SDRAM controller between
// the left (channel 0) and right (channel 1) sample-storage blocks, clk50 domain.
// Each channel owns a one-deep request slot; c_ready is the registered inverse
// of the slot's pending flag. Enables to the controller are one-cycle pulses.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a transaction that stays in
// a wait state for TIMEOUT_CYC cycles; the abort is reported on o_err and a read
// is answered with zero data. Without the macro o_err is tied low.
module sdram_port_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                i_clk50,
  input  logic                i_rst_n,
  input  logic [1:0]          i_c_valid,
  output logic [1:0]          o_c_ready,
  input  logic [1:0]          i_c_we,
  input  logic [2*ADDR_W-1:0] i_c_addr,
  input  logic [2*DATA_W-1:0] i_c_wdata,
  output logic [1:0]          o_c_rvalid,
  output logic [DATA_W-1:0]   o_c_rdata,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [ADDR_W-1:0]   o_rd_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic                o_wr_enable,
  output logic                o_rd_enable,
  input  logic [DATA_W-1:0]   i_rd_data,
  input  logic                i_rd_ready,
  input  logic                i_busy,
  output logic                o_grant,
  output logic [1:0]          o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t              r_state, w_state_next;

  // Request slots
  logic [1:0]          r_pend;
  logic [1:0]          r_ready;
  logic [1:0]          r_we;
  logic [ADDR_W-1:0]   r_addr  [2];
  logic [DATA_W-1:0]   r_wdata [2];
  logic [ADDR_W-1:0]   w_in_addr  [2];
  logic [DATA_W-1:0]   w_in_wdata [2];
  logic [1:0]          w_accept;
  logic [1:0]          w_clear;
  logic [1:0]          w_pend_next;

  // Arbitration and controller-side registers
  logic                r_grant, w_grant_next;
  logic                r_last_grant, w_last_grant_next;
  logic                w_pick;
  logic                w_cur_we;
  logic [1:0]          w_chan_mask;
  logic [ADDR_W-1:0]   r_xfer_addr, w_xfer_addr_next;
  logic [DATA_W-1:0]   r_xfer_wdata, w_xfer_wdata_next;
  logic                r_wr_enable, w_wr_enable_next;
  logic                r_rd_enable, w_rd_enable_next;
  logic [1:0]          r_rvalid, w_rvalid_next;
  logic [DATA_W-1:0]   r_rdata, w_rdata_next;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_err, w_err_next;
`endif

  // Per-channel views of the packed request buses
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign w_in_addr[gi]  = i_c_addr[gi*ADDR_W +: ADDR_W];
      assign w_in_wdata[gi] = i_c_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A slot accepts only while its registered ready is high; accept and clear
  // never hit the same slot because a pending slot is not ready.
  assign w_accept    = i_c_valid & r_ready;
  assign w_pend_next = (r_pend & ~w_clear) | w_accept;
  assign w_cur_we    = r_we[r_grant];
  assign w_chan_mask = r_grant ? 2'b10 : 2'b01;

  // Latch accepted requests into their slot
  always_ff @(posedge i_clk50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_accept[i]) begin
          r_we[i]    <= i_c_we[i];
          r_addr[i]  <= w_in_addr[i];
          r_wdata[i] <= w_in_wdata[i];
        end
      end
    end
  end

  // Pending flags and their registered inverse driving c_ready
  always_ff @(posedge i_clk50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= 2'b00;
      r_ready <= 2'b00;
    end else begin
      r_pend  <= w_pend_next;
      r_ready <= ~w_pend_next;
    end
  end

  // State register and registered controller/client outputs
  always_ff @(posedge i_clk50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_xfer_addr  <= '0;
      r_xfer_wdata <= '0;
      r_wr_enable  <= 1'b0;
      r_rd_enable  <= 1'b0;
      r_rvalid     <= 2'b00;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_xfer_addr  <= w_xfer_addr_next;
      r_xfer_wdata <= w_xfer_wdata_next;
      r_wr_enable  <= w_wr_enable_next;
      r_rd_enable  <= w_rd_enable_next;
      r_rvalid     <= w_rvalid_next;
      r_rdata      <= w_rdata_next;
    end
  end

  // Next-state and next-output logic; address/data only change on a new grant
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_xfer_addr_next  = r_xfer_addr;
    w_xfer_wdata_next = r_xfer_wdata;
    w_wr_enable_next  = 1'b0;
    w_rd_enable_next  = 1'b0;
    w_rvalid_next     = 2'b00;
    w_rdata_next      = r_rdata;
    w_clear           = 2'b00;
    w_pick            = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_err_next        = 2'b00;
`endif
    case (r_state)
      S_IDLE: begin
        if (!i_busy && (r_pend != 2'b00)) begin
          w_pick            = (r_pend == 2'b11) ? ~r_last_grant : r_pend[1];
          w_grant_next      = w_pick;
          w_last_grant_next = w_pick;
          w_xfer_addr_next  = r_addr[w_pick];
          w_xfer_wdata_next = r_wdata[w_pick];
          w_wr_enable_next  = r_we[w_pick];
          w_rd_enable_next  = ~r_we[w_pick];
          w_state_next      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!w_cur_we && i_rd_ready) begin
          w_rvalid_next = w_chan_mask;
          w_rdata_next  = i_rd_data;
          w_clear       = w_chan_mask;
          w_state_next  = S_IDLE;
        end else if (i_busy) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (w_cur_we) begin
          if (!i_busy) begin
            w_clear      = w_chan_mask;
            w_state_next = S_IDLE;
          end
        end else if (i_rd_ready) begin
          w_rvalid_next = w_chan_mask;
          w_rdata_next  = i_rd_data;
          w_clear       = w_chan_mask;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    // Watchdog abort only when the wait state would otherwise persist
    if (((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) &&
        (w_state_next == r_state) && (r_cnt == CNT_LIMIT)) begin
      w_err_next = w_chan_mask;
      if (!w_cur_we) begin
        w_rvalid_next = w_chan_mask;
        w_rdata_next  = '0;
      end
      w_clear      = w_chan_mask;
      w_state_next = S_IDLE;
    end
`endif
  end

`ifdef ARB_TIMEOUT_EN
  // Wait-state cycle counter, restarted on every state change
  always_ff @(posedge i_clk50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 2'b00;
    end else begin
      r_err <= w_err_next;
      if ((w_state_next != r_state) ||
          !((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE))) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_LIMIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 2'b00;
`endif

  assign o_c_ready   = r_ready;
  assign o_c_rvalid  = r_rvalid;
  assign o_c_rdata   = r_rdata;
  assign o_wr_addr   = r_xfer_addr;
  assign o_rd_addr   = r_xfer_addr;
  assign o_wr_data   = r_xfer_wdata;
  assign o_wr_enable = r_wr_enable;
  assign o_rd_enable = r_rd_enable;
  assign o_grant     = r_grant;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural SDRAM controller model plus a
// scoreboard of expected issues (per channel), grant order, read returns and
// watchdog errors. Timeout scenario is built only when ARB_TIMEOUT_EN is set.
module tb_sdram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 24;
`ifdef ARB_TIMEOUT_EN
  localparam int TO_CYC = 20;
`else
  localparam int TO_CYC = 1023;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } iss_t;

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] d;
    logic          to;
  } ret_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    c_valid = 2'b00;
  logic [1:0]    c_we = 2'b00;
  logic [2*AW-1:0] c_addr = '0;
  logic [2*DW-1:0] c_wdata = '0;
  logic [1:0]    c_ready, c_rvalid, err;
  logic [DW-1:0] c_rdata, wr_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_enable, rd_enable, grant;
  logic [DW-1:0] rd_data = '0;
  logic          rd_ready, busy;

  // controller model state
  logic m_busy = 1'b0, m_rdy = 1'b0, m_spur = 1'b0, refresh = 1'b0, m_hang = 1'b0;
  logic m_start = 1'b0, m_read = 1'b0, prev_en = 1'b0, prev_rdy = 1'b0;
  int   m_cnt = 0;
  int   m_lat = 6;
  int   n_wr = 0, n_issue = 0;

  iss_t       iss_q0[$], iss_q1[$];
  ret_t       ret_q[$];
  logic [1:0] err_q[$];
  logic       exp_grant[$];
  logic [DW-1:0] rdq[$];

  iss_t m_e;
  ret_t m_r;
  bit   m_have;

  int n_vec = 0;
  int n_bad = 0;

  assign rd_ready = m_rdy | m_spur;
  assign busy     = m_busy | refresh;

  always #10 clk = ~clk;

  sdram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk50(clk), .i_rst_n(rst_n),
    .i_c_valid(c_valid), .o_c_ready(c_ready), .i_c_we(c_we),
    .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .o_wr_addr(wr_addr), .o_rd_addr(rd_addr), .o_wr_data(wr_data),
    .o_wr_enable(wr_enable), .o_rd_enable(rd_enable),
    .i_rd_data(rd_data), .i_rd_ready(rd_ready), .i_busy(busy),
    .o_grant(grant), .o_err(err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Monitor (first) and controller model (second), both on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_rdy = 0; m_cnt = 0; m_start = 0; prev_en = 0; prev_rdy = 0;
    end else begin
      if (wr_enable || rd_enable) begin
        n_issue++;
        if (wr_enable) n_wr++;
        chk_eq("en_one_cycle", prev_en, 0);
        chk_eq("en_exclusive", wr_enable & rd_enable, 0);
        chk_eq("en_busy_clear", busy, 0);
        if (exp_grant.size() != 0) chk_eq("grant_order", grant, exp_grant.pop_front());
        m_have = grant ? (iss_q1.size() != 0) : (iss_q0.size() != 0);
        chk_eq("issue_expected", m_have, 1);
        if (m_have) begin
          m_e = grant ? iss_q1.pop_front() : iss_q0.pop_front();
          chk_eq("issue_we", wr_enable, m_e.we);
          chk_eq("issue_addr", m_e.we ? wr_addr : rd_addr, m_e.a);
          if (m_e.we) chk_eq("issue_wdata", wr_data, m_e.d);
        end
        prev_en = 1;
      end else begin
        prev_en = 0;
      end
      if (c_rvalid != 2'b00) begin
        m_have = (ret_q.size() != 0);
        chk_eq("rvalid_expected", m_have, 1);
        if (m_have) begin
          m_r = ret_q.pop_front();
          chk_eq("rvalid_chan", c_rvalid, m_r.ch ? 2'b10 : 2'b01);
          chk_eq("rdata", c_rdata, m_r.d);
          if (!m_r.to) chk_eq("rvalid_after_rd_ready", prev_rdy, 1);
        end
      end
      if (err != 2'b00) begin
        m_have = (err_q.size() != 0);
        chk_eq("err_expected", m_have, 1);
        if (m_have) chk_eq("err_chan", err, err_q.pop_front());
      end
      // controller: busy starts the cycle after an enable, read data on its last busy cycle
      m_rdy = 0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 1 && m_read && !m_hang) begin
          m_rdy = 1;
          rd_data = (rdq.size() != 0) ? rdq.pop_front() : 16'hDEAD;
        end
        if (m_cnt == 0) m_busy = 0;
      end
      if (m_start) begin
        m_start = 0; m_busy = 1; m_cnt = m_lat;
      end
      if (wr_enable || rd_enable) begin
        m_start = 1; m_read = rd_enable;
      end
      prev_rdy = m_rdy | m_spur;
    end
  end

  task automatic send(input int ch, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   t;
    iss_t e;
    t = 0;
    @(negedge clk);
    while (!c_ready[ch] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      chk_eq("ready_wait", c_ready[ch], 1);
    end else begin
      c_valid[ch] = 1'b1;
      c_we[ch] = we;
      c_addr[ch*AW +: AW] = a;
      c_wdata[ch*DW +: DW] = d;
      e.we = we; e.a = a; e.d = d;
      if (ch != 0) iss_q1.push_back(e); else iss_q0.push_back(e);
      @(posedge clk);
      #1 c_valid[ch] = 1'b0;
    end
  endtask

  task automatic push_ret(input bit ch, input logic [DW-1:0] d, input bit to);
    ret_t r;
    r.ch = ch; r.d = d; r.to = to;
    ret_q.push_back(r);
  endtask

  task automatic settle(input string tag, input int max);
    int t;
    t = 0;
    while (t < max && !(iss_q0.size() == 0 && iss_q1.size() == 0 && ret_q.size() == 0 &&
                        err_q.size() == 0 && c_ready == 2'b11 && !busy)) begin
      @(negedge clk);
      t++;
    end
    chk_eq({tag, "_drained"}, iss_q0.size() + iss_q1.size() + ret_q.size() + err_q.size(), 0);
    chk_eq({tag, "_ready"}, c_ready, 2'b11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int en_seen;
    int iss0;
    // reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_c_ready", c_ready, 2'b00);
    chk_eq("rst_wr_enable", wr_enable, 0);
    chk_eq("rst_rd_enable", rd_enable, 0);
    chk_eq("rst_grant", grant, 0);
    chk_eq("rst_rvalid", c_rvalid, 2'b00);
    chk_eq("rst_err", err, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("c_ready_after_reset", c_ready, 2'b11);
    chk_eq("grant_after_reset", grant, 0);

    // simultaneous reads: left wins the first tie
    rdq.push_back(16'hAAAA); rdq.push_back(16'h5555);
    push_ret(0, 16'hAAAA, 0); push_ret(1, 16'h5555, 0);
    exp_grant.push_back(0); exp_grant.push_back(1);
    fork
      send(0, 0, 24'h000100, 16'h0000);
      send(1, 0, 24'h000200, 16'h0000);
    join
    settle("dual_read", 200);

    // both channels streaming writes: grants alternate L,R,...
    for (int k = 0; k < 16; k++) exp_grant.push_back(k[0]);
    fork
      for (int k = 0; k < 8; k++) send(0, 1, 24'h001000 + 24'(k), 16'h0100 + 16'(k));
      for (int k = 0; k < 8; k++) send(1, 1, 24'h002000 + 24'(k), 16'h0200 + 16'(k));
    join
    settle("stream", 1500);
    chk_eq("stream_grants_used", exp_grant.size(), 0);

    // single left write, stray rd_ready during the write wait is ignored
    iss0 = n_wr;
    exp_grant.push_back(0);
    send(0, 1, 24'h000010, 16'h1234);
    repeat (5) @(negedge clk);
    m_spur = 1'b1;
    @(negedge clk);
    m_spur = 1'b0;
    settle("left_write", 200);
    chk_eq("wr_pulse_count", n_wr - iss0, 1);

    // stray rd_ready while idle
    @(negedge clk) m_spur = 1'b1;
    @(negedge clk) m_spur = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("idle_rd_ready_ignored", c_rvalid, 2'b00);

    // request during refresh: no issue until busy drops, then next cycle
    refresh = 1'b1;
    rdq.push_back(16'hBEEF);
    push_ret(1, 16'hBEEF, 0);
    send(1, 0, 24'h003456, 16'h0000);
    en_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_enable || rd_enable) en_seen++;
    end
    chk_eq("no_issue_while_busy", en_seen, 0);
    refresh = 1'b0;
    @(negedge clk);
    chk_eq("issue_after_refresh", rd_enable, 1);
    settle("refresh", 200);

    // reset in the middle of a read aborts it without a return
    rdq.push_back(16'h7777);
    send(0, 0, 24'h000055, 16'h0000);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    rdq.delete();
    iss_q0.delete();
    iss0 = n_issue;
    repeat (2) @(negedge clk);
    chk_eq("abort_rvalid_in_reset", c_rvalid, 2'b00);
    chk_eq("abort_ready_in_reset", c_ready, 2'b00);
    rst_n = 1'b1;
    en_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (c_rvalid != 2'b00) en_seen++;
    end
    chk_eq("abort_no_rvalid", en_seen, 0);
    chk_eq("abort_no_reissue", n_issue - iss0, 0);
    chk_eq("abort_ready", c_ready, 2'b11);

`ifdef ARB_TIMEOUT_EN
    // read that never returns: watchdog error, zero data, then normal service
    m_hang = 1'b1;
    err_q.push_back(2'b10);
    push_ret(1, 16'h0000, 1);
    send(1, 0, 24'h000077, 16'h0000);
    settle("timeout", 300);
    m_hang = 1'b0;
    rdq.push_back(16'h1357);
    push_ret(1, 16'h1357, 0);
    send(1, 0, 24'h000078, 16'h0000);
    settle("after_timeout", 200);
`endif

    chk_eq("grant_queue_empty", exp_grant.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
